line_prefetch: RTL and testbench
================================

LINE_PREFETCH -- requirements
Module: line_prefetch

Interface
REQ-001 SHALL: parameter COLS, default 640, cells per displayed row (one 8-bit cell per pixel column).
REQ-002 SHALL: parameter ROWS, default 480, displayed rows.
REQ-003 SHALL: parameter VTOTAL, default 525, vcount period including blanking.
REQ-004 SHALL: parameter BASE_ADDR, default 23'h0, memory address of cell (row 0, col 0).
REQ-005 SHALL: parameter MAX_OUTST, default 4, maximum outstanding memory reads.
REQ-006 SHALL: clk  input  1  system clock, 50 MHz.
REQ-007 SHALL: reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL: hcount  input  11  display timing counter, 0..1599; pixel column = hcount[10:1].
REQ-009 SHALL: vcount  input  10  display row counter, 0..VTOTAL-1.
REQ-010 SHALL: address  output  23  Avalon-MM master read address.
REQ-011 SHALL: read  output  1  Avalon-MM read request.
REQ-012 SHALL: waitrequest  input  1  slave stall; request accepted on cycle with read=1, waitrequest=0.
REQ-013 SHALL: readdata  input  8  returned cell value.
REQ-014 SHALL: readdatavalid  input  1  readdata valid, responses in request order.
REQ-015 SHALL: pixel  output  8  cell value for current display position, to renderer.
REQ-016 SHALL: busy  output  1  row fetch in progress.
REQ-017 SHALL: underrun  output  1  sticky: fetch trigger arrived while busy.

Function
REQ-018 SHALL: hold two COLS x 8 line banks; row r written to and displayed from bank r[0].
REQ-019 SHALL: trigger fetch on the cycle hcount==0: for vcount in 0..ROWS-2 fetch row vcount+1; for vcount==VTOTAL-1 fetch row 0; no trigger otherwise.
REQ-020 SHALL: FSM states IDLE, ISSUE, DRAIN; IDLE->ISSUE on trigger; ISSUE->DRAIN when COLS requests accepted; DRAIN->IDLE when COLS responses received.
REQ-021 SHALL: in ISSUE assert read when issued<COLS and outstanding<MAX_OUTST; address = BASE_ADDR + row*COLS + issued, computed by incremental add (no multiplier).
REQ-022 SHALL: hold address and read stable while waitrequest=1.
REQ-023 SHALL: outstanding counter +1 on accept, -1 on readdatavalid, unchanged on both same cycle; never exceed MAX_OUTST.
REQ-024 SHALL: write readdata to bank row[0] at index = responses received, incrementing on each readdatavalid.
REQ-025 SHALL: ignore readdatavalid in IDLE.
REQ-026 SHALL: busy=1 in ISSUE and DRAIN.
REQ-027 SHALL: trigger while busy sets underrun (held until reset), is dropped; current fetch completes unaltered.
REQ-028 SHALL: pixel registered, one-cycle latency: pixel = bank vcount[0][hcount[10:1]] when hcount<2*COLS and vcount<ROWS, else 8'h00.

Reset
REQ-029 SHALL: on reset, immediately: FSM IDLE, read=0, address=0, pixel=0, busy=0, underrun=0, counters 0; banks not cleared.
REQ-030 SHALL: reset mid-fetch abandons it; responses arriving after reset ignored; next trigger starts a clean fetch.

Structure
REQ-031 SHALL: shared package vga_pkg holds HACTIVE/HTOTAL/VACTIVE/VTOTAL constants and fetch state enum.
REQ-032 SHALL: one sub-module line_bank (1W/1R 8-bit RAM, registered read) instantiated twice.

Verification
REQ-033 SHALL: mem[a]=a[7:0], 0-wait, latency 2; vcount=5,hcount=0 -> first address 3840, row 6 filled; at vcount=6 pixel after hcount=2k equals (3840+k)[7:0].
REQ-034 SHALL: waitrequest=1 for 3 cycles at first request -> read=1, address constant 3 cycles, then advances.
REQ-035 SHALL: read latency 10 -> outstanding never >4; all 640 cells correct.
REQ-036 SHALL: waitrequest high 3 of 4 cycles -> fetch exceeds 1600 cycles; underrun=1 at next hcount==0, stays 1.
REQ-037 SHALL: vcount=524,hcount=0 -> fetch row 0, first address BASE_ADDR; vcount=479 -> no trigger.
REQ-038 SHALL: reset after 100 accepts -> read=0, busy=0 same cycle; late readdatavalid ignored; next fetch data correct.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared display timing constants and the line-fetch state encoding.
package vga_pkg;

  localparam int HACTIVE = 640;
  localparam int HTOTAL  = 800;
  localparam int VACTIVE = 480;
  localparam int VTOTAL  = 525;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/line_bank.sv
// One line buffer: single write port, single read port, registered read data.
module line_bank #(
  parameter int DEPTH  = 640,
  parameter int AW     = $clog2(DEPTH),
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write incoming cells and register the read port every cycle.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/line_prefetch.sv
// Prefetches the next display row from Avalon-MM memory into a ping-pong
// pair of line banks while the current row is being displayed.
module line_prefetch #(
  parameter int          COLS      = vga_pkg::HACTIVE,
  parameter int          ROWS      = vga_pkg::VACTIVE,
  parameter int          VTOTAL    = vga_pkg::VTOTAL,
  parameter logic [22:0] BASE_ADDR = 23'h0,
  parameter int          MAX_OUTST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  output logic [22:0] address,
  output logic        read,
  input  logic        waitrequest,
  input  logic [7:0]  readdata,
  input  logic        readdatavalid,
  output logic [7:0]  pixel,
  output logic        busy,
  output logic        underrun
);

  import vga_pkg::*;

  localparam int IW = $clog2(COLS);
  localparam int CW = $clog2(COLS + 1);
  localparam int OW = $clog2(MAX_OUTST + 1);

  fetch_state_t  state, state_nx;
  logic [CW-1:0] issued, rcvd;
  logic [OW-1:0] outst;
  logic          bank_sel;
  logic          trig;
  logic [9:0]    trig_row;
  logic          accept, rsp;
  logic          vld;
  logic [IW-1:0] rd_addr;
  logic [7:0]    q0, q1;
  logic          vld_p0, sel_p0;

  // Row start address by shift-and-add over the row bits (no multiplier).
  function automatic logic [22:0] row_base(input logic [9:0] r);
    logic [22:0] acc;
    acc = BASE_ADDR;
    for (int i = 0; i < 10; i++)
      if (r[i]) acc = acc + (23'(COLS) << i);
    return acc;
  endfunction

  // Fetch trigger at start of line: next row while active, row 0 on the last line.
  always_comb begin
    trig     = 1'b0;
    trig_row = '0;
    if (hcount == 11'd0) begin
      if (vcount <= 10'(ROWS - 2)) begin
        trig     = 1'b1;
        trig_row = vcount + 10'd1;
      end else if (vcount == 10'(VTOTAL - 1)) begin
        trig     = 1'b1;
        trig_row = '0;
      end
    end
  end

  // Next-state and bus request; read depends only on registered state so it
  // stays stable while the slave stalls.
  always_comb begin
    state_nx = state;
    busy     = (state != IDLE);
    read     = (state == ISSUE) && (issued < CW'(COLS)) && (outst < OW'(MAX_OUTST));
    unique case (state)
      IDLE:    if (trig) state_nx = ISSUE;
      ISSUE:   if (read && !waitrequest && issued == CW'(COLS - 1)) state_nx = DRAIN;
      DRAIN:   if (rsp && rcvd == CW'(COLS - 1)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign accept = read & ~waitrequest;
  assign rsp    = readdatavalid & (state != IDLE);

  // Fetch control: state, request/response counters, address walk, underrun flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      issued   <= '0;
      rcvd     <= '0;
      outst    <= '0;
      address  <= '0;
      bank_sel <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state <= state_nx;
      if (trig && busy) underrun <= 1'b1;
      if (state == IDLE && trig) begin
        issued   <= '0;
        rcvd     <= '0;
        bank_sel <= trig_row[0];
        address  <= row_base(trig_row);
      end else begin
        if (accept) begin
          issued  <= issued + CW'(1);
          address <= address + 23'd1;
        end
        if (rsp) rcvd <= rcvd + CW'(1);
      end
      case ({accept, rsp})
        2'b10:   outst <= outst + OW'(1);
        2'b01:   outst <= outst - OW'(1);
        default: outst <= outst;
      endcase
    end
  end

  assign vld     = (hcount < 11'(2 * COLS)) && (vcount < 10'(ROWS));
  assign rd_addr = vld ? IW'(hcount[10:1]) : '0;

  line_bank #(.DEPTH(COLS), .AW(IW), .DATA_W(8)) u_bank0 (
    .clk   (clk),
    .we    (rsp & ~bank_sel),
    .waddr (rcvd[IW-1:0]),
    .wdata (readdata),
    .raddr (rd_addr),
    .rdata (q0)
  );

  line_bank #(.DEPTH(COLS), .AW(IW), .DATA_W(8)) u_bank1 (
    .clk   (clk),
    .we    (rsp & bank_sel),
    .waddr (rcvd[IW-1:0]),
    .wdata (readdata),
    .raddr (rd_addr),
    .rdata (q1)
  );

  // Stage p0: display qualifiers registered alongside the bank read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      sel_p0 <= 1'b0;
    end else begin
      vld_p0 <= vld;
      sel_p0 <= vcount[0];
    end
  end

  // Select the bank for the displayed row; blank outside the active area.
  always_comb begin
    pixel = 8'h00;
    if (vld_p0) pixel = sel_p0 ? q1 : q0;
  end

endmodule

// File: tb/tb_line_prefetch.sv
// Self-checking bench for line_prefetch: Avalon slave model plus pixel scoreboard.
module tb_line_prefetch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [10:0] hcount = 11'd1;
  logic [9:0]  vcount = 10'd0;
  logic [22:0] address;
  logic        read;
  logic        waitrequest;
  logic [7:0]  readdata;
  logic        readdatavalid;
  logic [7:0]  pixel;
  logic        busy;
  logic        underrun;

  int checks = 0;
  int failures = 0;

  line_prefetch dut (
    .clk           (clk),
    .reset         (reset),
    .hcount        (hcount),
    .vcount        (vcount),
    .address       (address),
    .read          (read),
    .waitrequest   (waitrequest),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .pixel         (pixel),
    .busy          (busy),
    .underrun      (underrun)
  );

  always #10 clk = ~clk;

  // Slave model state: mem[a] = a[7:0], configurable latency and stall pattern.
  typedef struct {
    int         due;
    logic [7:0] data;
  } rsp_t;

  rsp_t        rq[$];
  logic [22:0] acc_q[$];
  int          pix_q[$];
  int          cyc = 0;
  int          lat = 2;
  int          wmode = 0;
  int          stalls = 0;
  int          max_outst = 0;
  int          hold_err = 0;
  logic        prev_stall = 1'b0;
  logic [22:0] prev_addr = '0;

  initial begin
    waitrequest   = 1'b0;
    readdatavalid = 1'b0;
    readdata      = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      if (prev_stall && (read !== 1'b1 || address !== prev_addr)) hold_err++;
      case (wmode)
        1: begin
          if (read === 1'b1 && stalls < 3) begin
            waitrequest = 1'b1;
            stalls++;
          end else waitrequest = 1'b0;
        end
        2:       waitrequest = ((cyc % 4) != 0);
        default: waitrequest = 1'b0;
      endcase
      if (read === 1'b1 && !waitrequest) begin
        acc_q.push_back(address);
        rq.push_back('{cyc + lat, address[7:0]});
      end
      prev_stall = (read === 1'b1) && waitrequest;
      prev_addr  = address;
      readdatavalid = 1'b0;
      readdata      = 8'h00;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        readdatavalid = 1'b1;
        readdata      = rq[0].data;
        void'(rq.pop_front());
      end
      if (rq.size() > max_outst) max_outst = rq.size();
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected pixel for a display position when row v has been fetched.
  function automatic int px(input int v, input int h);
    if (h < 1280 && v < 480) return (v * 640 + h / 2) & 255;
    return 0;
  endfunction

  // Count accepted addresses that differ from the row-r address sequence.
  function automatic int addr_errs(input int r);
    int e = 0;
    for (int i = 0; i < acc_q.size(); i++)
      if (acc_q[i] !== 23'(r * 640 + i)) e++;
    return e;
  endfunction

  // One cycle: score the pixel expected from the previous cycle, then drive.
  task automatic drive(input int h, input int v, input int exp);
    int e;
    @(negedge clk);
    if (pix_q.size() > 0) begin
      e = pix_q.pop_front();
      if (e >= 0) begin
        checks++;
        if (pixel !== 8'(e)) begin
          failures++;
          $display("FAIL pixel: got %02h want %02h (h=%0d v=%0d)", pixel, 8'(e), hcount, vcount);
        end
      end
    end
    hcount = 11'(h);
    vcount = 10'(v);
    pix_q.push_back(exp);
  endtask

  task automatic clear_stats();
    acc_q.delete();
    pix_q.delete();
    max_outst = 0;
    hold_err  = 0;
    stalls    = 0;
  endtask

  task automatic do_reset();
    hcount = 11'd1;
    reset  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset  = 1'b0;
  endtask

  task automatic wait_idle(input int v, input int budget);
    int used = 0;
    while (busy === 1'b1 && used < budget) begin
      drive(1, v, -1);
      used++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL fetch_done: busy=%b after %0d cycles", busy, used);
    end
  endtask

  task automatic display_row(input int v);
    for (int h = 1; h < 1600; h++) drive(h, v, px(v, h));
    drive(1, v, -1);
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (read !== 1'b0) begin failures++; $display("FAIL rst_read: got %b want 0", read); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL rst_underrun: got %b want 0", underrun); end
    checks++; if (address !== 23'd0) begin failures++; $display("FAIL rst_address: got %0d want 0", address); end
    checks++; if (pixel !== 8'h00) begin failures++; $display("FAIL rst_pixel: got %02h want 00", pixel); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_fetch_basic();
    logic [22:0] a0;
    do_reset(); clear_stats(); lat = 2; wmode = 0;
    drive(0, 5, -1);
    drive(1, 5, -1);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy: got %b want 1", busy); end
    wait_idle(5, 3000);
    a0 = (acc_q.size() > 0) ? acc_q[0] : '1;
    checks++; if (acc_q.size() !== 640) begin failures++; $display("FAIL basic_count: got %0d want 640", acc_q.size()); end
    checks++; if (a0 !== 23'd3840) begin failures++; $display("FAIL basic_first_addr: got %0d want 3840", a0); end
    checks++; if (addr_errs(6) !== 0) begin failures++; $display("FAIL basic_addr_seq: got %0d bad want 0", addr_errs(6)); end
    display_row(6);
  endtask

  task automatic test_stall();
    int n = 0;
    do_reset(); clear_stats(); lat = 2; wmode = 1;
    drive(0, 7, -1);
    while (read !== 1'b1 && n < 20) begin drive(1, 7, -1); n++; end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (read !== 1'b1 || address !== 23'd5120) begin
        failures++;
        $display("FAIL stall_hold[%0d]: got read=%b addr=%0d want read=1 addr=5120", k, read, address);
      end
      drive(1, 7, -1);
    end
    drive(1, 7, -1);
    checks++; if (address !== 23'd5121) begin failures++; $display("FAIL stall_advance: got %0d want 5121", address); end
    wait_idle(7, 3000);
    checks++; if (acc_q.size() !== 640) begin failures++; $display("FAIL stall_count: got %0d want 640", acc_q.size()); end
    checks++; if (addr_errs(8) !== 0) begin failures++; $display("FAIL stall_addr_seq: got %0d bad want 0", addr_errs(8)); end
    checks++; if (hold_err !== 0) begin failures++; $display("FAIL stall_stable: got %0d changes want 0", hold_err); end
  endtask

  task automatic test_latency();
    do_reset(); clear_stats(); lat = 10; wmode = 0;
    drive(0, 8, -1);
    drive(1, 8, -1);
    wait_idle(8, 5000);
    checks++; if (acc_q.size() !== 640) begin failures++; $display("FAIL lat_count: got %0d want 640", acc_q.size()); end
    checks++; if (addr_errs(9) !== 0) begin failures++; $display("FAIL lat_addr_seq: got %0d bad want 0", addr_errs(9)); end
    checks++; if (max_outst !== 4) begin failures++; $display("FAIL lat_max_outst: got %0d want 4", max_outst); end
    display_row(9);
  endtask

  task automatic test_underrun();
    do_reset(); clear_stats(); lat = 2; wmode = 2;
    drive(0, 10, -1);
    drive(1, 10, -1);
    checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL ur_clear: got %b want 0", underrun); end
    for (int h = 2; h < 1600; h++) drive(h, 10, -1);
    drive(0, 11, -1);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ur_slow_fetch: busy got %b want 1", busy); end
    drive(1, 11, -1);
    checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL ur_set: got %b want 1", underrun); end
    wait_idle(11, 4000);
    checks++; if (acc_q.size() !== 640) begin failures++; $display("FAIL ur_count: got %0d want 640", acc_q.size()); end
    checks++; if (addr_errs(11) !== 0) begin failures++; $display("FAIL ur_addr_seq: got %0d bad want 0", addr_errs(11)); end
    checks++; if (hold_err !== 0) begin failures++; $display("FAIL ur_stable: got %0d changes want 0", hold_err); end
    wmode = 0;
    display_row(11);
    checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL ur_sticky: got %b want 1", underrun); end
  endtask

  task automatic test_wrap();
    logic [22:0] a0;
    do_reset(); clear_stats(); lat = 2; wmode = 0;
    drive(0, 479, -1);
    for (int k = 0; k < 5; k++) drive(1, 479, -1);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wrap_479_busy: got %b want 0", busy); end
    checks++; if (acc_q.size() !== 0) begin failures++; $display("FAIL wrap_479_reads: got %0d want 0", acc_q.size()); end
    drive(0, 524, -1);
    drive(1, 524, -1);
    wait_idle(524, 3000);
    a0 = (acc_q.size() > 0) ? acc_q[0] : '1;
    checks++; if (a0 !== 23'd0) begin failures++; $display("FAIL wrap_first_addr: got %0d want 0", a0); end
    checks++; if (addr_errs(0) !== 0 || acc_q.size() !== 640) begin
      failures++; $display("FAIL wrap_addr_seq: got %0d bad of %0d want 0 of 640", addr_errs(0), acc_q.size());
    end
    display_row(0);
    drive(10, 480, 0);
    drive(600, 500, 0);
    drive(1, 500, -1);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    do_reset(); clear_stats(); lat = 10; wmode = 0;
    drive(0, 12, -1);
    while (acc_q.size() < 100 && n < 1000) begin drive(1, 12, -1); n++; end
    checks++; if (acc_q.size() < 100) begin failures++; $display("FAIL rm_accepts: got %0d want >=100", acc_q.size()); end
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    checks++; if (read !== 1'b0) begin failures++; $display("FAIL rm_read: got %b want 0", read); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rm_busy: got %b want 0", busy); end
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    while (rq.size() > 0 && n < 50) begin drive(1, 12, -1); n++; end
    drive(1, 12, -1);
    checks++; if (busy !== 1'b0 || read !== 1'b0) begin
      failures++; $display("FAIL rm_late_ignored: got busy=%b read=%b want 0 0", busy, read);
    end
    clear_stats();
    drive(0, 12, -1);
    drive(1, 12, -1);
    wait_idle(12, 5000);
    checks++; if (acc_q.size() !== 640) begin failures++; $display("FAIL rm_count: got %0d want 640", acc_q.size()); end
    checks++; if (addr_errs(13) !== 0) begin failures++; $display("FAIL rm_addr_seq: got %0d bad want 0", addr_errs(13)); end
    display_row(13);
  endtask

  initial begin
    test_reset();
    test_fetch_basic();
    test_stall();
    test_latency();
    test_underrun();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
